// File: rtl/bcd_scan_pkg.sv
// Shared widths, segment constants and the prescaler terminal helper for bcd_scan_counter.
// No logic of its own; imported by the counter top and its seg7 decoder.
package bcd_scan_pkg;

    localparam int BCD_W   = 4;
    localparam int PRESC_W = 24;
    localparam int SCAN_W  = 16;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [6:0]       seg_t;

    // A zero selector falls back to the build-time period.
    function automatic logic [PRESC_W-1:0] period_terminal(
        input logic [PRESC_W-1:0] max_count,
        input logic [7:0]         sel
    );
        return (sel == 8'd0) ? max_count : {6'b0, sel, 10'b0};
    endfunction

endpackage

// File: rtl/bcd_scan_counter_seg7.sv
// Purpose: BCD digit to active-high {g,f,e,d,c,b,a} seven-segment pattern; 10..15 blank.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_scan_counter_seg7
    import bcd_scan_pkg::*;
(
    input  bcd_t counter,
    output seg_t segments
);

    always_comb begin
        case (counter)
            4'd0:    segments = SEG_ZERO;
            4'd1:    segments = 7'b0000110;
            4'd2:    segments = 7'b1011011;
            4'd3:    segments = 7'b1001111;
            4'd4:    segments = 7'b1100110;
            4'd5:    segments = 7'b1101101;
            4'd6:    segments = 7'b1111101;
            4'd7:    segments = 7'b0000111;
            4'd8:    segments = 7'b1111111;
            4'd9:    segments = 7'b1101111;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Purpose: prescaled N-digit up/down BCD counter with multiplexed 7-seg scan (BCD_LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: value/tick/wrap register one edge after prescaler terminal; segments lag value by one cycle.
// Backpressure: none; free-running, run/clear only gate the count path.
module bcd_scan_counter
    import bcd_scan_pkg::*;
#(
    parameter int                  DIGITS    = 4,
    parameter logic [PRESC_W-1:0]  MAX_COUNT = 24'd10_000_000,
    parameter logic [SCAN_W-1:0]   SCAN_DIV  = 16'd10_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                period_sel,
    input  logic                      run,
    input  logic                      up,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic                      tick,
    output logic                      wrap,
    output logic [6:0]                segments,
    output logic [DIGITS-1:0]         digit_en
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRESC_W-1:0]      presc_q;
    logic [PRESC_W-1:0]      terminal;
    logic                    presc_hit;
    logic [BCD_W*DIGITS-1:0] value_nxt;
    logic                    chain_wrap;

    logic [SCAN_W-1:0]       scan_q;
    logic                    scan_end;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    bcd_t                    sel_digit;
    seg_t                    seg_dec;
    seg_t                    seg_nxt;

    // >= rather than == so a lowered terminal mid-period reloads at once.
    assign terminal  = period_terminal(MAX_COUNT, period_sel);
    assign presc_hit = run && (presc_q >= terminal);

    always_comb begin : bcd_chain
        logic carry;
        bcd_t d;
        value_nxt = value;
        carry     = 1'b1;
        d         = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = value[k*BCD_W +: BCD_W];
            if (carry) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        d     = 4'd0;
                        carry = 1'b1;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d     = 4'd9;
                        carry = 1'b1;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            value_nxt[k*BCD_W +: BCD_W] = d;
        end
        chain_wrap = carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            value   <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (clear) begin
            presc_q <= '0;
            value   <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (presc_hit) begin
            presc_q <= '0;
            value   <= value_nxt;
            tick    <= 1'b1;
            wrap    <= chain_wrap;
        end else begin
            if (run) begin
                presc_q <= presc_q + PRESC_W'(1);
            end
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

    assign scan_end = (scan_q == SCAN_DIV - SCAN_W'(1));

    always_comb begin
        idx_d = idx_q;
        if (scan_end) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Mux on the next index so segments and digit_en land on the same edge.
    always_comb begin
        sel_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_digit = value[k*BCD_W +: BCD_W];
            end
        end
    end

    bcd_scan_counter_seg7 u_seg7 (
        .counter  (sel_digit),
        .segments (seg_dec)
    );

`ifdef BCD_LEADING_ZERO_BLANK_EN
    always_comb begin : lz_blank
        logic blank;
        blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                blank = 1'b1;
                for (int j = k; j < DIGITS; j++) begin
                    if (value[j*BCD_W +: BCD_W] != '0) begin
                        blank = 1'b0;
                    end
                end
            end
        end
        seg_nxt = blank ? SEG_BLANK : seg_dec;
    end
`else
    assign seg_nxt = seg_dec;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q   <= '0;
            idx_q    <= '0;
            digit_en <= DIGITS'(1);
            segments <= SEG_ZERO;
        end else begin
            scan_q   <= scan_end ? '0 : scan_q + SCAN_W'(1);
            idx_q    <= idx_d;
            digit_en <= DIGITS'(1) << idx_d;
            segments <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: a 2-digit counting instance and a 4-digit scan instance.
module tb_bcd_scan_counter;

    logic        clk;
    logic        reset;
    logic [7:0]  period_sel_a;
    logic        run_a, up_a, clear_a;
    logic [7:0]  value_a;
    logic        tick_a, wrap_a;
    logic [6:0]  segments_a;
    logic [1:0]  digit_en_a;

    logic [7:0]  period_sel_b;
    logic        run_b, up_b, clear_b;
    logic [15:0] value_b;
    logic        tick_b, wrap_b;
    logic [6:0]  segments_b;
    logic [3:0]  digit_en_b;

    typedef struct {
        logic [7:0] val;
        logic       wrap;
        int         gap;
    } tick_exp_t;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
    } scan_exp_t;

    tick_exp_t tick_sb[$];
    scan_exp_t scan_sb[$];

    int n_total = 0;
    int n_bad   = 0;
    int gap     = 0;
    int stray   = 0;
    int edges;

    bcd_scan_counter #(.DIGITS(2), .MAX_COUNT(24'd9), .SCAN_DIV(16'd4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .period_sel (period_sel_a),
        .run        (run_a),
        .up         (up_a),
        .clear      (clear_a),
        .value      (value_a),
        .tick       (tick_a),
        .wrap       (wrap_a),
        .segments   (segments_a),
        .digit_en   (digit_en_a)
    );

    bcd_scan_counter #(.DIGITS(4), .MAX_COUNT(24'd0), .SCAN_DIV(16'd4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .period_sel (period_sel_b),
        .run        (run_b),
        .up         (up_b),
        .clear      (clear_b),
        .value      (value_b),
        .tick       (tick_b),
        .wrap       (wrap_b),
        .segments   (segments_b),
        .digit_en   (digit_en_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            gap++;
            if (tick_a) stray++;
        end
    endtask

    task automatic push_tick(input logic [7:0] val, input logic w, input int g);
        tick_exp_t e;
        e.val  = val;
        e.wrap = w;
        e.gap  = g;
        tick_sb.push_back(e);
    endtask

    task automatic drain_tick(input int budget);
        tick_exp_t e;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            gap++;
            seen = tick_a;
        end
        e = tick_sb.pop_front();
        check("tick_seen", 32'(seen), 1);
        if (seen) begin
            check("tick_gap", gap, e.gap);
            check("tick_val", value_a, e.val);
            check("tick_wrap", wrap_a, e.wrap);
        end
        gap = 0;
    endtask

    task automatic scan_check(input int shown, input int n, input string tag);
        scan_exp_t e;
        int idx, p, dig;
        for (int i = 1; i <= n; i++) begin
            idx = ((edges + i) / 4) % 4;
            p = 1;
            for (int j = 0; j < idx; j++) p = p * 10;
            dig   = (shown / p) % 10;
            e.en  = 4'(1 << idx);
            e.seg = seg_of(dig);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (idx > 0 && shown < p) e.seg = 7'h00;
`endif
            scan_sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            step(1);
            e = scan_sb.pop_front();
            check({tag, "_en"}, digit_en_b, e.en);
            check({tag, "_seg"}, segments_b, e.seg);
        end
    endtask

    initial begin
        reset = 1'b1;
        period_sel_a = 8'd0; run_a = 1'b0; up_a = 1'b1; clear_a = 1'b0;
        period_sel_b = 8'd0; run_b = 1'b0; up_b = 1'b1; clear_b = 1'b0;
        #23;
        check("rst_val", value_a, 0);
        check("rst_tick", tick_a, 0);
        check("rst_wrap", wrap_a, 0);
        check("rst_en", digit_en_a, 2'b01);
        check("rst_seg", segments_a, 7'h3F);
        check("rst_en_b", digit_en_b, 4'b0001);
        @(negedge clk);
        reset = 1'b0;

        // Scan instance: one tick per clock, count to 1234 and freeze.
        run_b = 1'b1;
        step(1234);
        run_b = 1'b0;
        check("b_val1234", value_b, 16'h1234);
        step(3);
        check("b_tick_idle", tick_b, 0);
        check("b_wrap_idle", wrap_b, 0);
        scan_check(1234, 16, "scan");

        clear_b = 1'b1;
        step(1);
        clear_b = 1'b0;
        check("b_clear", value_b, 0);
        run_b = 1'b1;
        step(7);
        run_b = 1'b0;
        check("b_val7", value_b, 16'h0007);
        step(2);
        scan_check(7, 8, "blank");

        // Counting instance: 100 up ticks, 00 -> 99 -> 00.
        check("a_idle", value_a, 0);
        gap = 0;
        stray = 0;
        for (int i = 1; i <= 100; i++) push_tick(to_bcd(i % 100), i == 100, 10);
        run_a = 1'b1;
        for (int i = 0; i < 100; i++) drain_tick(50);

        up_a = 1'b0;
        push_tick(8'h99, 1'b1, 10);
        push_tick(8'h98, 1'b0, 10);
        drain_tick(50);
        drain_tick(50);

        // clear lands on the would-be tick edge
        step(9);
        check("pre_clear", value_a, 8'h98);
        clear_a = 1'b1;
        step(1);
        clear_a = 1'b0;
        check("clr_val", value_a, 0);
        check("clr_tick", tick_a, 0);
        check("clr_wrap", wrap_a, 0);
        check("clr_stray", stray, 0);
        gap = 0;
        up_a = 1'b1;
        push_tick(8'h01, 1'b0, 10);
        drain_tick(50);

        step(4);
        run_a = 1'b0;
        step(25);
        run_a = 1'b1;
        push_tick(8'h02, 1'b0, 35);
        drain_tick(80);

        period_sel_a = 8'd2;
        step(2000);
        check("psel_stray", stray, 0);
        period_sel_a = 8'd1;
        push_tick(8'h03, 1'b0, 2001);
        push_tick(8'h04, 1'b0, 1025);
        drain_tick(3000);
        drain_tick(3000);
        period_sel_a = 8'd0;

        // Asynchronous reset between edges.
        step(3);
        #2 reset = 1'b1;
        #1;
        check("arst_val", value_a, 0);
        check("arst_tick", tick_a, 0);
        check("arst_wrap", wrap_a, 0);
        check("arst_en", digit_en_a, 2'b01);
        check("arst_seg", segments_a, 7'h3F);
        #1 reset = 1'b0;
        gap = 0;
        push_tick(8'h01, 1'b0, 10);
        drain_tick(50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
